i2s_rx: RTL and testbench

//  I2S receiver: deserializes a stereo I2S stream (e.g. from an ADC) into parallel
//  L/R sample words in the clk domain, as the receive-side counterpart of i2s_tx.
//  It samples sclk/lrclk/sdi as data. It does not need to own the bit clock, so it
//  can consume i2s_clk outputs or an external master. Output is one valid strobe
//  per stereo frame, to feed DSP blocks downstream.

---
 rtl/abies_i2s_pkg.sv | 17 +
 rtl/i2s_edge_sync.sv | 45 ++++
 rtl/i2s_rx.sv | 119 +++++++++++
 tb/tb_i2s_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/abies_i2s_pkg.sv
// Shared I2S types and constants for the receive and transmit blocks.
package abies_i2s_pkg;

  typedef enum logic {
    I2S_LEFT  = 1'b0,
    I2S_RIGHT = 1'b1
  } i2s_ch_t;

  typedef enum logic {
    SEEK,
    RUN
  } i2s_rx_state_t;

  // Serial data trails word select by one bit clock.
  localparam int I2S_DATA_DELAY = 1;

endpackage

// File: rtl/i2s_edge_sync.sv
// Optional synchronizer for sclk/lrclk/sdi plus a one-clk sclk rising-edge strobe.
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic lrclk,
  input  logic sdi,
  output logic lrclk_s,
  output logic sdi_s,
  output logic rise
);

  logic [2:0] synced;
  logic       sclk_q;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign synced = {sclk, lrclk, sdi};
  end else begin : g_chain
    logic [2:0] chain [SYNC_STAGES];

    // All three lines share one chain so data stays aligned with its sclk edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= 3'b000;
      end else begin
        chain[0] <= {sclk, lrclk, sdi};
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end

    assign synced = chain[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_q <= 1'b0;
    else        sclk_q <= synced[2];
  end

  assign lrclk_s = synced[1];
  assign sdi_s   = synced[0];
  assign rise    = synced[2] & ~sclk_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserializes stereo slots into parallel L/R words with one valid per frame.
module i2s_rx
  import abies_i2s_pkg::*;
#(
  parameter int DW          = 24,
  parameter int SYNC_STAGES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          lrclk,
  input  logic          sdi,
  output logic [DW-1:0] l_sample,
  output logic [DW-1:0] r_sample,
  output logic          valid,
  output logic          short_err
);

  localparam int CW = $clog2(DW + 1);

  logic          lrclk_s;
  logic          sdi_s;
  logic          rise;

  i2s_rx_state_t state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] shift;
  logic [DW-1:0] l_hold;
  i2s_ch_t       lr_last;
  logic          primed;

  logic          take;
  logic [DW-1:0] shift_step;
  logic [CW-1:0] cnt_step;
  logic [DW-1:0] word;
  i2s_ch_t       lr_now;
  logic          boundary;
  logic          l_load;
  logic          emit;
  logic          slot_short;

  i2s_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .lrclk  (lrclk),
    .sdi    (sdi),
    .lrclk_s(lrclk_s),
    .sdi_s  (sdi_s),
    .rise   (rise)
  );

  assign take       = bit_cnt < CW'(DW);
  assign shift_step = take ? {shift[DW-2:0], sdi_s} : shift;
  assign cnt_step   = take ? bit_cnt + 1'b1 : bit_cnt;
  // Short slots come out left-aligned; any stale bits are shifted off the top.
  assign word       = shift_step << (CW'(DW) - cnt_step);
  assign lr_now     = i2s_ch_t'(lrclk_s);
  assign boundary   = rise && (lr_now != lr_last);
  assign slot_short = boundary && (state == RUN) && (cnt_step < CW'(DW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEEK;
    else        state <= state_next;
  end

  // lr_last resets to RIGHT without having seen it, so the first rise after reset
  // only primes the detector; a real 1->0 edge is needed to trust a left-slot start.
  always_comb begin
    state_next = state;
    l_load     = 1'b0;
    emit       = 1'b0;
    if (boundary) begin
      case (state)
        SEEK: if (primed && lr_now == I2S_LEFT) state_next = RUN;
        RUN: begin
          if (lr_now == I2S_RIGHT) l_load = 1'b1;
          else                     emit   = 1'b1;
        end
        default: state_next = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift     <= '0;
      l_hold    <= '0;
      lr_last   <= I2S_RIGHT;
      primed    <= 1'b0;
      l_sample  <= '0;
      r_sample  <= '0;
      valid     <= 1'b0;
      short_err <= 1'b0;
    end else begin
      valid <= emit;
      if (rise) begin
        primed <= 1'b1;
        shift  <= shift_step;
        if (boundary) begin
          bit_cnt <= '0;
          lr_last <= lr_now;
        end else begin
          bit_cnt <= cnt_step;
        end
      end
      if (l_load) l_hold <= word;
      if (emit) begin
        l_sample <= l_hold;
        r_sample <= word;
      end
      if (slot_short) short_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed and random checks of i2s_rx, with unsynchronized and 2-stage-synchronized instances.
module tb_i2s_rx;

  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic lrclk = 1'b1;
  logic sdi = 1'b0;

  logic [DW-1:0] l0, r0, l2, r2;
  logic          valid0, short0, valid2, short2;

  always #5 clk = ~clk;

  i2s_rx #(.DW(DW), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk), .sdi(sdi),
    .l_sample(l0), .r_sample(r0), .valid(valid0), .short_err(short0)
  );

  i2s_rx #(.DW(DW), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk), .sdi(sdi),
    .l_sample(l2), .r_sample(r2), .valid(valid2), .short_err(short2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcnt0 = 0;
  int vcnt2 = 0;
  int vcyc0 = 0;
  int vcyc0_prev = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid0) begin
      vcnt0++;
      vcyc0_prev = vcyc0;
      vcyc0 = cyc;
    end
    if (valid2) vcnt2++;
  end

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            slot;
  } vec_t;

  vec_t tv [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    sclk = 1'b0;
    lrclk = lr;
    sdi = d;
    #40;
    sclk = 1'b1;
    #40;
  endtask

  // Word select flips on the slot's last bit (one-bit I2S delay); bits past DW are 1s.
  task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int nbits, input int slot);
    logic d;
    for (int k = 0; k < slot; k++) begin
      if (k < nbits) d = w[DW-1-k];
      else           d = 1'b1;
      send_bit((k == slot - 1) ? ~ch : ch, d);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot);
    send_slot(1'b0, l, DW, slot);
    send_slot(1'b1, r, DW, slot);
  endtask

  initial begin
    int off;
    int base0, base2;
    logic [DW-1:0] rl, rr;

    tv[0] = '{24'h123456, 24'hABCDEF, 32};
    tv[1] = '{24'h800000, 24'h7FFFFF, 32};
    tv[2] = '{24'hFFFFFF, 24'hFFFFFF, 24};
    tv[3] = '{24'h0F0F0F, 24'hF0F0F0, 32};
    tv[4] = '{24'h000001, 24'hFFFFFE, 25};

    // Stimulus edges land at a random offset that never coincides with a clk edge.
    off = int'($urandom_range(0, 7));
    off = (off < 4) ? off + 1 : off + 2;
    #off;

    #30;
    chk("reset_l", 64'(l0), 64'h0);
    chk("reset_r", 64'(r0), 64'h0);
    chk("reset_valid", 64'(valid0), 64'h0);
    chk("reset_short", 64'(short0), 64'h0);
    rst_n = 1'b1;

    send_frame(24'h111111, 24'h222222, 24);
    #50;
    chk("startup_no_valid0", 64'(vcnt0), 64'd0);
    chk("startup_no_valid2", 64'(vcnt2), 64'd0);

    base0 = vcnt0;
    for (int i = 0; i < 3; i++) send_frame(24'h123456, 24'hABCDEF, 32);
    #50;
    chk("loop_valid_count", 64'(vcnt0 - base0), 64'd3);
    chk("loop_frame_gap", 64'(vcyc0 - vcyc0_prev), 64'd512);
    chk("loop_l", 64'(l0), 64'h123456);
    chk("loop_r", 64'(r0), 64'hABCDEF);

    for (int i = 0; i < 5; i++) begin
      base0 = vcnt0;
      base2 = vcnt2;
      send_frame(tv[i].l, tv[i].r, tv[i].slot);
      #50;
      $display("vec %0d slot=%0d L=%h R=%h -> dut0 L=%h R=%h", i, tv[i].slot, tv[i].l, tv[i].r, l0, r0);
      chk($sformatf("vec%0d_l0", i), 64'(l0), 64'(tv[i].l));
      chk($sformatf("vec%0d_r0", i), 64'(r0), 64'(tv[i].r));
      chk($sformatf("vec%0d_valid0", i), 64'(vcnt0 - base0), 64'd1);
      chk($sformatf("vec%0d_short0", i), 64'(short0), 64'h0);
      chk($sformatf("vec%0d_lr2", i), {16'h0, l2, r2}, {16'h0, tv[i].l, tv[i].r});
      chk($sformatf("vec%0d_valid2", i), 64'(vcnt2 - base2), 64'd1);
    end

    send_slot(1'b0, 24'hA5A500, 16, 16);
    send_slot(1'b1, 24'h123456, DW, 24);
    #50;
    chk("short_l", 64'(l0), 64'hA5A500);
    chk("short_r", 64'(r0), 64'h123456);
    chk("short_err_set", 64'(short0), 64'h1);
    chk("short_err_set2", 64'(short2), 64'h1);
    send_frame(24'h654321, 24'h0000FF, 24);
    #50;
    chk("short_err_sticky", 64'(short0), 64'h1);
    chk("after_short_lr", {16'h0, l0, r0}, {16'h0, 24'h654321, 24'h0000FF});

    base0 = vcnt0;
    send_slot(1'b0, 24'hCAFE01, DW, 24);
    for (int k = 0; k < 12; k++) send_bit(1'b1, rr[0]);
    rst_n = 1'b0;
    #1;
    chk("midrst_l", 64'(l0), 64'h0);
    chk("midrst_r", 64'(r0), 64'h0);
    chk("midrst_short", 64'(short0), 64'h0);
    chk("midrst_short2", 64'(short2), 64'h0);
    for (int k = 12; k < 24; k++) send_bit((k == 23) ? 1'b0 : 1'b1, 1'b1);
    rl = 24'h5A5A5A;
    for (int k = 0; k < 10; k++) send_bit(1'b0, rl[23-k]);
    chk("in_reset_no_valid", 64'(vcnt0 - base0), 64'd0);
    rst_n = 1'b1;
    for (int k = 10; k < 24; k++) send_bit((k == 23) ? 1'b1 : 1'b0, rl[23-k]);
    send_slot(1'b1, 24'h3C3C3C, DW, 24);
    #50;
    chk("partial_frame_no_valid", 64'(vcnt0 - base0), 64'd0);
    send_frame(24'h13579B, 24'h2468AC, 24);
    #50;
    chk("resync_valid", 64'(vcnt0 - base0), 64'd1);
    chk("resync_lr", {16'h0, l0, r0}, {16'h0, 24'h13579B, 24'h2468AC});
    chk("resync_lr2", {16'h0, l2, r2}, {16'h0, 24'h13579B, 24'h2468AC});

    base2 = vcnt2;
    for (int i = 0; i < 100; i++) begin
      rl = DW'($urandom);
      rr = DW'($urandom);
      send_frame(rl, rr, 24);
      #50;
      chk($sformatf("rand%0d_lr2", i), {16'h0, l2, r2}, {16'h0, rl, rr});
    end
    chk("rand_valid2_count", 64'(vcnt2 - base2), 64'd100);
    chk("rand_short2", 64'(short2), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
